// File: rtl/mem_access_unit_if.sv
// Bundle of EXE-side pipeline inputs, MEM-side pipeline outputs and SRAM pins
// seen by the memory-access stage.
interface mem_access_unit_if #(
  parameter int unsigned SRAM_AW = 18
);
  logic               mem_r_en;
  logic               mem_w_en;
  logic               wb_en_in;
  logic [3:0]         dest_in;
  logic [31:0]        alu_res;
  logic [31:0]        val_rm;
  logic               freeze;
  logic               wb_en_out;
  logic               mem_r_en_out;
  logic [3:0]         dest_out;
  logic [31:0]        alu_res_out;
  logic [31:0]        mem_data_out;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic               sram_dq_oe;
  logic [15:0]        sram_dq_in;
  logic               sram_we_n;

  modport slave (
    input  mem_r_en, mem_w_en, wb_en_in, dest_in, alu_res, val_rm, sram_dq_in,
    output freeze, wb_en_out, mem_r_en_out, dest_out, alu_res_out, mem_data_out,
    output sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport master (
    output mem_r_en, mem_w_en, wb_en_in, dest_in, alu_res, val_rm, sram_dq_in,
    input  freeze, wb_en_out, mem_r_en_out, dest_out, alu_res_out, mem_data_out,
    input  sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: 32-bit loads/stores split into two half-word
// SRAM transactions with wait states, stalling upstream stages while busy.
module mem_access_unit #(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int unsigned SRAM_AW     = 18
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  localparam int unsigned CntW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e             r_state, w_state_d;
  logic [CntW-1:0]    r_cnt, w_cnt_d;
  logic [31:0]        r_data;

  logic               w_req, w_write, w_idle_req;
  logic               w_lo, w_hi, w_freeze, w_drive, w_last;
  logic [31:0]        w_off;
  logic [SRAM_AW-2:0] w_word;
  logic               w_unused_off;

  assign w_req        = bus.mem_r_en | bus.mem_w_en;
  assign w_write      = bus.mem_w_en;
  assign w_off        = bus.alu_res - ADDR_BASE;
  assign w_word       = w_off[SRAM_AW:2];
  assign w_unused_off = ^{w_off[31:SRAM_AW+1], w_off[1:0]};

  // The request cycle in IDLE is already the first cycle of the low phase, so
  // the stall lasts exactly 2*(WAIT_STATES+1) cycles counted from the request.
  assign w_idle_req = (r_state == StIdle) & w_req;
  assign w_lo       = w_idle_req | (r_state == StLow);
  assign w_hi       = (r_state == StHigh);
  assign w_freeze   = w_lo | w_hi;
  assign w_last     = (r_state == StIdle) ? (WAIT_STATES == 0) : (r_cnt == CntLast);

  // SRAM pins are released during reset even if a request is still presented.
  assign w_drive    = w_freeze & rst;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          if (WAIT_STATES == 0) begin
            w_state_d = StHigh;
            w_cnt_d   = '0;
          end else begin
            w_state_d = StLow;
            w_cnt_d   = CntW'(1);
          end
        end
      end
      StLow: begin
        if (w_last) begin
          w_state_d = StHigh;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StHigh: begin
        if (w_last) begin
          w_state_d = StDone;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StDone: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_lo && w_last && !w_write) r_data[15:0]  <= bus.sram_dq_in;
      if (w_hi && w_last && !w_write) r_data[31:16] <= bus.sram_dq_in;
    end
  end

  always_comb begin
    bus.freeze       = w_freeze;
    bus.wb_en_out    = ~w_freeze & bus.wb_en_in;
    bus.mem_r_en_out = ~w_freeze & bus.mem_r_en & ~bus.mem_w_en;
    bus.dest_out     = bus.dest_in;
    bus.alu_res_out  = bus.alu_res;
    bus.mem_data_out = r_data;

    bus.sram_addr    = '0;
    if (w_drive && w_lo) begin
      bus.sram_addr = {w_word, 1'b0};
    end else if (w_drive && w_hi) begin
      bus.sram_addr = {w_word, 1'b1};
    end

    bus.sram_dq_oe  = w_drive & w_write;
    bus.sram_we_n   = ~(w_drive & w_write);
    bus.sram_dq_out = '0;
    if (w_drive && w_write) begin
      bus.sram_dq_out = w_lo ? bus.val_rm[15:0] : bus.val_rm[31:16];
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised scoreboard bench for mem_access_unit: two instances (2 and 0 wait
// states), a transaction-level reference model and per-cycle expected records.
module tb_mem_access_unit;

  localparam int unsigned Aw = 18;

  typedef struct {
    logic          sel;
    logic          freeze;
    logic          wb;
    logic          mr;
    logic [3:0]    dest;
    logic [31:0]   alu;
    logic          chk_data;
    logic [31:0]   data;
    logic          we_n;
    logic          oe;
    logic [Aw-1:0] addr;
    logic          chk_dq;
    logic [15:0]   dq;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel;
  logic        s_r, s_w, s_wb;
  logic [3:0]  s_dest;
  logic [31:0] s_alu, s_rm;

  int tests = 0;
  int fails = 0;

  exp_t        exp_q[$];
  logic [15:0] mm    [2][128];
  logic [31:0] mdata [2];
  logic [15:0] sram  [2][128];

  mem_access_unit_if #(.SRAM_AW(Aw)) bus2 ();
  mem_access_unit_if #(.SRAM_AW(Aw)) bus0 ();

  mem_access_unit #(.WAIT_STATES(2), .ADDR_BASE(32'd1024), .SRAM_AW(Aw)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  mem_access_unit #(.WAIT_STATES(0), .ADDR_BASE(32'd1024), .SRAM_AW(Aw)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  assign bus2.mem_r_en   = s_r & ~sel;
  assign bus2.mem_w_en   = s_w & ~sel;
  assign bus2.wb_en_in   = s_wb;
  assign bus2.dest_in    = s_dest;
  assign bus2.alu_res    = s_alu;
  assign bus2.val_rm     = s_rm;
  assign bus2.sram_dq_in = sram[0][bus2.sram_addr[6:0]];

  assign bus0.mem_r_en   = s_r & sel;
  assign bus0.mem_w_en   = s_w & sel;
  assign bus0.wb_en_in   = s_wb;
  assign bus0.dest_in    = s_dest;
  assign bus0.alu_res    = s_alu;
  assign bus0.val_rm     = s_rm;
  assign bus0.sram_dq_in = sram[1][bus0.sram_addr[6:0]];

  function automatic logic [15:0] pat(input int k, input int i);
    return 16'(i * 32'h1357) ^ ((k != 0) ? 16'h5A5A : 16'hA5A5);
  endfunction

  // SRAM behaviour: a write commits only after the strobe has been held at one
  // address for a full phase, so an abandoned write leaves memory unchanged.
  logic          sram_init = 1'b0;
  int            run2 = 0;
  int            run0 = 0;
  logic [Aw-1:0] last2, last0;
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < 128; i++) begin
        sram[0][i] = pat(0, i);
        sram[1][i] = pat(1, i);
      end
      sram_init = 1'b1;
    end
    if (!bus2.sram_we_n) begin
      run2  = (run2 > 0 && last2 == bus2.sram_addr) ? run2 + 1 : 1;
      last2 = bus2.sram_addr;
      if (run2 == 3) sram[0][bus2.sram_addr[6:0]] = bus2.sram_dq_out;
    end else begin
      run2 = 0;
    end
    if (!bus0.sram_we_n) begin
      run0  = (run0 > 0 && last0 == bus0.sram_addr) ? run0 + 1 : 1;
      last0 = bus0.sram_addr;
      if (run0 == 1) sram[1][bus0.sram_addr[6:0]] = bus0.sram_dq_out;
    end else begin
      run0 = 0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, required 0x%0h", nm, $time, act, req);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t          e;
    logic          a_fr, a_wb, a_mr, a_we, a_oe;
    logic [3:0]    a_dest;
    logic [31:0]   a_alu, a_data;
    logic [Aw-1:0] a_addr;
    logic [15:0]   a_dq;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.sel) begin
        a_fr = bus0.freeze;      a_wb = bus0.wb_en_out;    a_mr = bus0.mem_r_en_out;
        a_we = bus0.sram_we_n;   a_oe = bus0.sram_dq_oe;   a_dest = bus0.dest_out;
        a_alu = bus0.alu_res_out; a_data = bus0.mem_data_out;
        a_addr = bus0.sram_addr; a_dq = bus0.sram_dq_out;
      end else begin
        a_fr = bus2.freeze;      a_wb = bus2.wb_en_out;    a_mr = bus2.mem_r_en_out;
        a_we = bus2.sram_we_n;   a_oe = bus2.sram_dq_oe;   a_dest = bus2.dest_out;
        a_alu = bus2.alu_res_out; a_data = bus2.mem_data_out;
        a_addr = bus2.sram_addr; a_dq = bus2.sram_dq_out;
      end
      check("freeze", 32'(a_fr), 32'(e.freeze));
      check("wb_en_out", 32'(a_wb), 32'(e.wb));
      check("mem_r_en_out", 32'(a_mr), 32'(e.mr));
      check("dest_out", 32'(a_dest), 32'(e.dest));
      check("alu_res_out", a_alu, e.alu);
      check("sram_we_n", 32'(a_we), 32'(e.we_n));
      check("sram_dq_oe", 32'(a_oe), 32'(e.oe));
      check("sram_addr", 32'(a_addr), 32'(e.addr));
      if (e.chk_data) check("mem_data_out", a_data, e.data);
      if (e.chk_dq) check("sram_dq_out", 32'(a_dq), 32'(e.dq));
    end
  end

  function automatic logic [Aw-1:0] lo_addr(input logic [31:0] a);
    logic [31:0] word;
    word = (a - 32'd1024) >> 2;
    return Aw'(word * 2);
  endfunction

  function automatic exp_t pass_rec();
    exp_t e;
    e.sel = sel;       e.freeze = 1'b0;    e.wb = s_wb;        e.mr = s_r & ~s_w;
    e.dest = s_dest;   e.alu = s_alu;      e.chk_data = 1'b1;  e.data = mdata[sel];
    e.we_n = 1'b1;     e.oe = 1'b0;        e.addr = '0;        e.chk_dq = 1'b1;
    e.dq = 16'h0;
    return e;
  endfunction

  function automatic exp_t stall_rec(input int ph);
    exp_t e;
    e          = pass_rec();
    e.freeze   = 1'b1;
    e.wb       = 1'b0;
    e.mr       = 1'b0;
    e.chk_data = 1'b0;
    e.we_n     = ~s_w;
    e.oe       = s_w;
    e.addr     = lo_addr(s_alu) + Aw'(ph);
    e.chk_dq   = s_w;
    e.dq       = (ph != 0) ? s_rm[31:16] : s_rm[15:0];
    return e;
  endfunction

  function automatic exp_t reset_rec();
    exp_t e;
    logic req;
    req      = s_r | s_w;
    e        = pass_rec();
    e.freeze = req;
    e.wb     = req ? 1'b0 : s_wb;
    e.mr     = req ? 1'b0 : (s_r & ~s_w);
    e.data   = 32'h0;
    return e;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic r, input logic w, input logic wb, input logic [3:0] dest,
                       input logic [31:0] alu, input logic [31:0] rm);
    int            ws;
    logic [Aw-1:0] lo;
    ws = (sel != 0) ? 0 : 2;
    s_r = r; s_w = w; s_wb = wb; s_dest = dest; s_alu = alu; s_rm = rm;
    if (!(r || w)) begin
      exp_q.push_back(pass_rec());
      cycle();
    end else begin
      lo = lo_addr(alu);
      for (int ph = 0; ph < 2; ph++)
        for (int k = 0; k <= ws; k++) exp_q.push_back(stall_rec(ph));
      if (w) begin
        mm[sel][int'(lo % 128)]       = rm[15:0];
        mm[sel][int'((lo + 1) % 128)] = rm[31:16];
      end else begin
        mdata[sel] = {mm[sel][int'((lo + 1) % 128)], mm[sel][int'(lo % 128)]};
      end
      exp_q.push_back(pass_rec());
      repeat (2 * ws + 3) cycle();
    end
  endtask

  task automatic rand_op();
    int          kind;
    logic [31:0] a;
    kind = $urandom_range(3, 0);
    if ($urandom_range(7, 0) == 0) a = 32'd1020;
    else a = 32'd1024 + 4 * $urandom_range(31, 0) + $urandom_range(3, 0);
    case (kind)
      0:       issue(1'b0, 1'b0, 1'($urandom), 4'($urandom), $urandom, $urandom);
      1:       issue(1'b1, 1'b0, 1'($urandom), 4'($urandom), a, $urandom);
      2:       issue(1'b0, 1'b1, 1'($urandom), 4'($urandom), a, $urandom);
      default: issue(1'b1, 1'b1, 1'($urandom), 4'($urandom), a, $urandom);
    endcase
  endtask

  // Store on the 2-wait-state unit, reset in the second cycle of its high phase.
  task automatic reset_mid_store(input logic [31:0] a, input logic [31:0] rm);
    logic [Aw-1:0] lo;
    s_r = 1'b0; s_w = 1'b1; s_wb = 1'b1; s_dest = 4'd9; s_alu = a; s_rm = rm;
    lo = lo_addr(a);
    for (int k = 0; k < 4; k++) exp_q.push_back(stall_rec((k < 3) ? 0 : 1));
    repeat (4) cycle();
    rst = 1'b0;
    mm[0][int'(lo % 128)] = rm[15:0];
    mdata[0] = 32'h0;
    mdata[1] = 32'h0;
    repeat (2) begin
      exp_q.push_back(reset_rec());
      cycle();
    end
    s_w = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    sel = 1'b0;
    rst = 1'b0;
    s_r = 1'b0; s_w = 1'b0; s_wb = 1'b0; s_dest = 4'd0; s_alu = 32'd0; s_rm = 32'd0;
    for (int k = 0; k < 2; k++) begin
      mdata[k] = 32'h0;
      for (int i = 0; i < 128; i++) mm[k][i] = pat(k, i);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      s_r = 1'($urandom); s_w = 1'($urandom); s_wb = 1'($urandom);
      s_dest = 4'($urandom); s_alu = $urandom; s_rm = $urandom;
      exp_q.push_back(reset_rec());
      cycle();
    end
    s_r = 1'b0; s_w = 1'b0; s_wb = 1'b0; s_dest = 4'd0; s_alu = 32'd0; s_rm = 32'd0;
    rst = 1'b1;

    issue(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    issue(1'b0, 1'b0, 1'b1, 4'd3, 32'h55, 32'd0);
    issue(1'b0, 1'b1, 1'b0, 4'd0, 32'd1028, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 1'b1, 4'd7, 32'd1028, 32'd0);
    repeat (40) rand_op();

    reset_mid_store(32'd1040, $urandom);
    issue(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    issue(1'b1, 1'b0, 1'b1, 4'd2, 32'd1040, 32'd0);

    sel = 1'b1;
    issue(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    issue(1'b0, 1'b1, 1'b0, 4'd0, 32'd1024, 32'h12345678);
    issue(1'b0, 1'b1, 1'b0, 4'd0, 32'd1032, 32'hCAFEF00D);
    issue(1'b1, 1'b0, 1'b1, 4'd1, 32'd1024, 32'd0);
    issue(1'b1, 1'b0, 1'b1, 4'd2, 32'd1032, 32'd0);
    repeat (30) rand_op();
    issue(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage of the five-stage ARM pipeline. It sits between the EXE-stage pipeline register and the MEM-stage pipeline register. Loads and stores are served from an external 16-bit-wide SRAM as two half-word transactions with configurable wait states. While an access is in flight, `freeze` stalls every earlier stage; non-memory instructions pass straight through.

## Interface
- `WAIT_STATES`, 2, extra cycles per half-word transaction; each half takes `WAIT_STATES+1` cycles.
- `ADDR_BASE`, 1024, byte address mapped to SRAM word 0.
- `SRAM_AW`, 18, SRAM half-word address width.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_r_en`  in  1  load request from EXE pipeline register.
- `mem_w_en`  in  1  store request from EXE pipeline register.
- `wb_en_in`  in  1  writeback enable from EXE pipeline register.
- `dest_in`  in  4  destination register.
- `alu_res`  in  32  ALU result; byte address for loads and stores.
- `val_rm`  in  32  store data.
- `freeze`  out  1  stall request to IF/ID/EXE stages and their pipeline registers.
- `wb_en_out`  out  1  writeback enable to MEM pipeline register.
- `mem_r_en_out`  out  1  load marker to MEM pipeline register.
- `dest_out`  out  4  destination register.
- `alu_res_out`  out  32  ALU result, passed through.
- `mem_data_out`  out  32  loaded word.
- `sram_addr`  out  `SRAM_AW`  SRAM half-word address.
- `sram_dq_out`  out  16  SRAM write data.
- `sram_dq_oe`  out  1  drive enable for `sram_dq_out`.
- `sram_dq_in`  in  16  SRAM read data.
- `sram_we_n`  out  1  SRAM write strobe, active low.

## Operation
- Address: `word = (alu_res - ADDR_BASE) >> 2`, truncated to `SRAM_AW-1` bits. Low half is at `{word,0}`, high half at `{word,1}`. There is no range check; the address wraps modulo 2^`SRAM_AW`.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if `mem_w_en` or `mem_r_en` is high, go to LOW. `mem_w_en` has priority; when both are high the access is a write.
  - LOW: runs for `WAIT_STATES+1` cycles, then goes to HIGH.
  - HIGH: runs for `WAIT_STATES+1` cycles, then goes to DONE.
  - DONE: one cycle, then IDLE.
- Wait counter: 0..`WAIT_STATES`. It resets to 0 on every phase entry.
- Write during LOW/HIGH:
  - `sram_dq_oe`=1, `sram_we_n`=0.
  - Data is `val_rm[15:0]` in LOW and `val_rm[31:16]` in HIGH.
  - `sram_addr` is stable for the whole phase.
- Read during LOW/HIGH:
  - `sram_we_n`=1, `sram_dq_oe`=0.
  - `sram_dq_in` is registered into the matching half of the data register on the last cycle of the phase.
- `freeze` is combinational: `(IDLE & (mem_r_en | mem_w_en)) | LOW | HIGH`. It is low in DONE, so the upstream stages advance on the DONE clock edge.
- Inputs are held stable by the frozen upstream register for the whole access. The unit does not latch them, except the read data register.
- Pipeline outputs:
  - In IDLE with no memory request, and in DONE: `wb_en_out=wb_en_in`, `mem_r_en_out=mem_r_en & ~mem_w_en`, `dest_out=dest_in`, `alu_res_out=alu_res`.
  - Whenever `freeze`=1: `wb_en_out=0` and `mem_r_en_out=0`, so the MEM register captures bubbles.
- `mem_data_out` = data register; valid in DONE and held until the next read completes.
- Idle SRAM pins: `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0.

## Timing
- Reset values: state IDLE, counter 0, data register 0, `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0, `mem_data_out`=0.
  - `freeze`, `wb_en_out`, `mem_r_en_out`, `dest_out` and `alu_res_out` follow the IDLE combinational rules; with all inputs 0 they are 0.
- Latency for an ALU instruction: 0 cycles, combinational pass-through, no stall.
- Latency for a load/store: `freeze` is high for `2*(WAIT_STATES+1)` cycles, then DONE lasts 1 cycle. With defaults that is 6 stall cycles, and the result is presented on the 7th cycle.
- Back-to-back memory ops: the next access enters LOW on the cycle after DONE. There are no idle SRAM cycles in between.
- Reset asserted mid-access (any state): all registers return to reset values immediately.
  - `sram_we_n` rises asynchronously; the partial write is abandoned.
  - `freeze` drops unless a request is present.
- `WAIT_STATES`=0: each phase is 1 cycle, giving 2 stall cycles.

## Test plan
- Reset: hold `rst`=0 with random inputs, then release. Required: `sram_we_n`=1, `sram_dq_oe`=0, `mem_data_out`=0, state IDLE. Without a memory request, `freeze`=0.
- ALU pass-through: `wb_en_in`=1, `dest_in`=3, `alu_res`=0x55, no memory request. Required, same cycle: `wb_en_out`=1, `dest_out`=3, `alu_res_out`=0x55, `freeze`=0.
- Store, defaults: `mem_w_en`=1, `alu_res`=1028, `val_rm`=0xDEADBEEF. Required:
  - `sram_addr`=2 with data 0xBEEF for 3 cycles, then `sram_addr`=3 with data 0xDEAD for 3 cycles.
  - `sram_we_n` low for all 6 cycles; `freeze` high for 6 cycles, then low.
- Load back: `mem_r_en`=1, `alu_res`=1028, `wb_en_in`=1, with an SRAM model. Required:
  - `wb_en_out`=0 during the 6 stall cycles.
  - In DONE: `mem_data_out`=0xDEADBEEF, `wb_en_out`=1, `mem_r_en_out`=1.
- Reset mid-access: pull `rst` low in the 2nd cycle of the HIGH phase of a store. Required: `sram_we_n`=1 immediately, state IDLE after release, SRAM high half unchanged.
- Back-to-back loads from 1024 and 1032 with `WAIT_STATES`=0. Required:
  - `freeze` pattern 1,1,0,1,1,0.
  - `sram_addr` sequence 0,1,4,5.
  - Both words returned in their DONE cycles.
